// File: rtl/pkt_tx.sv
// Serial packet transmitter: APB-loaded 64-bit packet FIFO, shifted out MSB first with an idle gap.
// Optional interrupt output and CTRL[3] irq_en are built only when PKT_TX_IRQ_EN is defined.
module pkt_tx #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] paddr,
    input  logic        psel,
    input  logic        pen,
    input  logic        p_write,
    input  logic [31:0] p_wdata,
    output logic [31:0] prdata,
    output logic        tx_data,
    output logic        tx_valid
`ifdef PKT_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nx_s;
    logic [63:0]    shreg_r;
    logic [5:0]     bitcnt_r;
    logic [GW-1:0]  gapcnt_r;
    logic [63:0]    mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic           tx_en_r;
    logic [31:0]    data_lo_r;
    logic [31:0]    data_hi_r;
    logic           overflow_r;
    logic           done_r;
    logic [15:0]    pkt_sent_r;
    logic [31:0]    prdata_r;

    logic           wr_s;
    logic           rd_s;
    logic           ctrl_wr_s;
    logic           status_wr_s;
    logic           push_s;
    logic           flush_s;
    logic           full_s;
    logic           empty_s;
    logic           push_ok_s;
    logic           pop_s;
    logic           last_bit_s;
    logic           gap_done_s;
    logic           busy_s;
    logic           irq_en_s;
    logic [7:0]     count_ext_s;
    logic [31:0]    rdata_s;

    assign wr_s        = psel & pen & p_write;
    assign rd_s        = psel & pen & ~p_write;
    assign ctrl_wr_s   = wr_s & (paddr == 32'h0000_0000);
    assign status_wr_s = wr_s & (paddr == 32'h0000_000C);
    assign push_s      = ctrl_wr_s & p_wdata[1];
    assign flush_s     = ctrl_wr_s & p_wdata[2];
    assign full_s      = (count_r == CW'(DEPTH));
    assign empty_s     = (count_r == {CW{1'b0}});
    // Flush overrides both a push and a pop on the same edge.
    assign push_ok_s   = push_s & ~full_s & ~flush_s;
    assign pop_s       = (state_r == ST_IDLE) & tx_en_r & ~empty_s & ~flush_s;
    assign last_bit_s  = (state_r == ST_SHIFT) & (bitcnt_r == 6'd63);
    assign gap_done_s  = (gapcnt_r == GW'(GAP_CYCLES - 1));
    assign busy_s      = (state_r != ST_IDLE);
    assign count_ext_s = 8'(count_r);

    assign tx_valid = (state_r == ST_SHIFT);
    assign tx_data  = (state_r == ST_SHIFT) & shreg_r[63];
    assign prdata   = prdata_r;

`ifdef PKT_TX_IRQ_EN
    logic irq_en_r;

    // Interrupt enable bit, only present in the irq build.
    always_ff @(posedge clk) begin
        if (!rst) begin
            irq_en_r <= 1'b0;
        end else if (ctrl_wr_s) begin
            irq_en_r <= p_wdata[3];
        end else begin
            irq_en_r <= irq_en_r;
        end
    end

    assign irq_en_s = irq_en_r;
    assign irq      = irq_en_r & done_r;
`else
    assign irq_en_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit_s) begin
                    state_nx_s = ST_GAP;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_GAP: begin
                if (gap_done_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_GAP;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Shift register, bit counter and gap counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg_r  <= 64'd0;
            bitcnt_r <= 6'd0;
            gapcnt_r <= {GW{1'b0}};
        end else if (pop_s) begin
            shreg_r  <= mem_r[rd_ptr_r];
            bitcnt_r <= 6'd0;
            gapcnt_r <= {GW{1'b0}};
        end else if (state_r == ST_SHIFT) begin
            shreg_r  <= {shreg_r[62:0], 1'b0};
            bitcnt_r <= bitcnt_r + 6'd1;
            gapcnt_r <= {GW{1'b0}};
        end else if (state_r == ST_GAP) begin
            shreg_r  <= shreg_r;
            bitcnt_r <= bitcnt_r;
            gapcnt_r <= gapcnt_r + GW'(1);
        end else begin
            shreg_r  <= shreg_r;
            bitcnt_r <= bitcnt_r;
            gapcnt_r <= gapcnt_r;
        end
    end

    // Packet storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= {data_hi_r, data_lo_r};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst || flush_s) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= push_ok_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
            rd_ptr_r <= pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Software-visible control, data and sticky status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_en_r    <= 1'b0;
            data_lo_r  <= 32'd0;
            data_hi_r  <= 32'd0;
            overflow_r <= 1'b0;
            done_r     <= 1'b0;
            pkt_sent_r <= 16'd0;
        end else begin
            tx_en_r    <= ctrl_wr_s ? p_wdata[0] : tx_en_r;
            data_lo_r  <= (wr_s && paddr == 32'h0000_0004) ? p_wdata : data_lo_r;
            data_hi_r  <= (wr_s && paddr == 32'h0000_0008) ? p_wdata : data_hi_r;
            // A new event wins over a clear on the same edge so it is never lost.
            overflow_r <= (push_s & full_s & ~flush_s) |
                          (overflow_r & ~(status_wr_s & p_wdata[3]));
            done_r     <= last_bit_s | (done_r & ~(status_wr_s & p_wdata[4]));
            pkt_sent_r <= last_bit_s ? pkt_sent_r + 16'd1 : pkt_sent_r;
        end
    end

    // Read data mux.
    always_comb begin
        rdata_s = 32'd0;
        case (paddr)
            32'h0000_0000: rdata_s = {28'd0, irq_en_s, 2'b00, tx_en_r};
            32'h0000_0004: rdata_s = data_lo_r;
            32'h0000_0008: rdata_s = data_hi_r;
            32'h0000_000C: rdata_s = {pkt_sent_r, 4'd0, count_ext_s[3:0], 3'd0,
                                      done_r, overflow_r, empty_s, full_s, busy_s};
            default:       rdata_s = 32'd0;
        endcase
    end

    // Registered read data, updated only on a read strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prdata_r <= 32'd0;
        end else if (rd_s) begin
            prdata_r <= rdata_s;
        end else begin
            prdata_r <= prdata_r;
        end
    end

endmodule

// File: tb/tb_pkt_tx.sv
// Scoreboard bench for pkt_tx: expected packets and read data are queued by the stimulus
// and compared by independent monitors as the DUT presents them.
module tb_pkt_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] paddr = 32'd0;
    logic        psel = 1'b0;
    logic        pen = 1'b0;
    logic        p_write = 1'b0;
    logic [31:0] p_wdata = 32'd0;
    logic [31:0] prdata;
    logic        tx_data;
    logic        tx_valid;
`ifdef PKT_TX_IRQ_EN
    logic        irq;
`endif

    pkt_tx #(.DEPTH(4), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .paddr(paddr), .psel(psel), .pen(pen),
        .p_write(p_write), .p_wdata(p_wdata), .prdata(prdata),
        .tx_data(tx_data), .tx_valid(tx_valid)
`ifdef PKT_TX_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int sb_errors = 0;
    int sb_checks = 0;
    int cycle = 0;
    int pkts_seen = 0;
    int starts[$];
    logic [63:0] exp_pkt[$];
    logic [31:0] exp_rd[$];
    logic rd_q = 1'b0;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        rd_q  <= psel & pen & ~p_write & rst;
    end

    // Read-data monitor.
    always @(negedge clk) begin
        if (rd_q) begin
            sb_checks++;
            if (exp_rd.size() == 0) begin
                sb_errors++;
                $display("FAIL rd_unexpected: prdata=%h, no read expected", prdata);
            end else begin
                logic [31:0] e;
                e = exp_rd.pop_front();
                if (prdata !== e) begin
                    sb_errors++;
                    $display("FAIL rd_data: got %h expected %h", prdata, e);
                end
            end
        end
    end

    // Serial packet monitor: collects a burst and checks length and payload when valid falls.
    logic [63:0] shv = 64'd0;
    int nbits = 0;
    always @(negedge clk) begin
        if (!rst) begin
            nbits = 0;
        end else if (tx_valid) begin
            if (nbits == 0) starts.push_back(cycle);
            shv = {shv[62:0], tx_data};
            nbits++;
        end else if (nbits != 0) begin
            sb_checks++;
            if (nbits != 64) begin
                sb_errors++;
                $display("FAIL burst_len: got %0d cycles expected 64", nbits);
            end
            sb_checks++;
            if (exp_pkt.size() == 0) begin
                sb_errors++;
                $display("FAIL pkt_unexpected: got %h, no packet expected", shv);
            end else begin
                logic [63:0] e;
                e = exp_pkt.pop_front();
                if (shv !== e) begin
                    sb_errors++;
                    $display("FAIL pkt_data: got %h expected %h", shv, e);
                end
            end
            pkts_seen++;
            nbits = 0;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        paddr = a; p_wdata = d; p_write = 1'b1; psel = 1'b1; pen = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; pen = 1'b0; p_write = 1'b0;
    endtask

    task automatic apb_rd(input logic [31:0] a, input logic [31:0] e);
        exp_rd.push_back(e);
        @(posedge clk); #1;
        paddr = a; p_write = 1'b0; psel = 1'b1; pen = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; pen = 1'b0;
    endtask

    task automatic load_push(input logic [63:0] d);
        apb_wr(32'h8, d[63:32]);
        apb_wr(32'h4, d[31:0]);
        apb_wr(32'h0, 32'h2);
    endtask

    task automatic wait_pkts(input int target, input int budget);
        int n = 0;
        while (pkts_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pkts_seen < target) begin
            errors++;
            $display("FAIL wait_pkts: got %0d packets expected %0d", pkts_seen, target);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!tx_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!tx_valid) begin
            errors++;
            $display("FAIL wait_valid: tx_valid still %b after %0d cycles", tx_valid, budget);
        end
    endtask

    initial begin
        int base;
        int seen;
        logic [63:0] d;

        // Reset state.
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        apb_rd(32'hC, 32'h0000_0004);
        apb_rd(32'h0, 32'h0000_0000);
        apb_rd(32'h4, 32'h0000_0000);

        // Single packet with first-bit latency.
        load_push(64'hA5A5_0000_0000_00FF);
        exp_pkt.push_back(64'hA5A5_0000_0000_00FF);
        apb_rd(32'hC, 32'h0000_0100);
        apb_wr(32'h0, 32'h1);
        @(negedge clk);
        check("latency_pre", 64'(tx_valid), 64'd0);
        @(negedge clk);
        check("latency_first", 64'(tx_valid), 64'd1);
        wait_pkts(1, 200);
        apb_rd(32'hC, 32'h0001_0014);
        apb_wr(32'hC, 32'h10);
        apb_rd(32'hC, 32'h0001_0004);

        // Overflow: fifth push is dropped.
        apb_wr(32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            d = 64'hC0DE_0000_0F0F_0000 + {32'(i), 32'(i)};
            load_push(d);
            if (i < 4) exp_pkt.push_back(d);
        end
        apb_rd(32'hC, 32'h0001_040A);
        apb_wr(32'hC, 32'h8);
        apb_rd(32'hC, 32'h0001_0402);

        // Back-to-back drain of the four queued packets.
        base = starts.size();
        apb_wr(32'h0, 32'h1);
        wait_pkts(5, 600);
        for (int k = 0; k < 3; k++) begin
            if (starts.size() > base + k + 1)
                check("b2b_spacing", 64'(starts[base+k+1] - starts[base+k]), 64'd67);
            else
                check("b2b_count", 64'(starts.size()), 64'(base + k + 2));
        end
        apb_rd(32'hC, 32'h0005_0014);
        apb_wr(32'hC, 32'h10);

        // Mid-packet disable with one packet still queued.
        apb_wr(32'h0, 32'h0);
        load_push(64'h0123_4567_89AB_CDEF);
        load_push(64'hFEDC_BA98_7654_3210);
        exp_pkt.push_back(64'h0123_4567_89AB_CDEF);
        exp_pkt.push_back(64'hFEDC_BA98_7654_3210);
        apb_wr(32'h0, 32'h1);
        wait_valid(20);
        repeat (10) @(negedge clk);
        apb_wr(32'h0, 32'h0);
        wait_pkts(6, 200);
        seen = pkts_seen;
        repeat (100) @(negedge clk);
        check("disabled_no_tx", 64'(pkts_seen), 64'(seen));
        apb_rd(32'hC, 32'h0006_0110);

        // Reset in the middle of the queued packet.
        apb_wr(32'h0, 32'h1);
        wait_valid(20);
        repeat (20) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        exp_pkt.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_tx_valid", 64'(tx_valid), 64'd0);
        check("midrst_tx_data", 64'(tx_data), 64'd0);
        #1 rst = 1'b1;
        apb_rd(32'hC, 32'h0000_0004);
        apb_rd(32'h0, 32'h0000_0000);
        apb_rd(32'h4, 32'h0000_0000);
        apb_rd(32'h8, 32'h0000_0000);

        // Flush wins over a simultaneous push.
        load_push(64'h1111_1111_2222_2222);
        load_push(64'h3333_3333_4444_4444);
        apb_rd(32'hC, 32'h0000_0200);
        apb_wr(32'h0, 32'h6);
        apb_rd(32'hC, 32'h0000_0004);
        seen = pkts_seen;
        apb_wr(32'h0, 32'h1);
        repeat (100) @(negedge clk);
        check("flush_no_tx", 64'(pkts_seen), 64'(seen));

        // Readback and optional interrupt.
        apb_wr(32'h4, 32'h1234_5678);
        apb_wr(32'h8, 32'h9ABC_DEF0);
        apb_wr(32'h0, 32'h9);
        apb_rd(32'h4, 32'h1234_5678);
        apb_rd(32'h8, 32'h9ABC_DEF0);
`ifdef PKT_TX_IRQ_EN
        apb_rd(32'h0, 32'h0000_0009);
        check("irq_idle", 64'(irq), 64'd0);
`else
        apb_rd(32'h0, 32'h0000_0001);
`endif
        apb_rd(32'h10, 32'h0000_0000);
        exp_pkt.push_back(64'h9ABC_DEF0_1234_5678);
        apb_wr(32'h0, 32'hB);
        wait_pkts(seen + 1, 200);
`ifdef PKT_TX_IRQ_EN
        check("irq_set", 64'(irq), 64'd1);
`endif
        apb_rd(32'hC, 32'h0001_0014);
        apb_wr(32'hC, 32'h10);
        @(negedge clk);
`ifdef PKT_TX_IRQ_EN
        check("irq_clear", 64'(irq), 64'd0);
`endif
        apb_rd(32'hC, 32'h0001_0004);

        repeat (4) @(negedge clk);
        check("exp_pkt_left", 64'(exp_pkt.size()), 64'd0);
        check("exp_rd_left", 64'(exp_rd.size()), 64'd0);
        errors += sb_errors;
        checks += sb_checks;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
